frame_checker: RTL and testbench
================================

FRAME_CHECKER -- requirements
Module: frame_checker

Interface
REQ-001 Parameter: MAX_PAYLOAD, 1500, largest accepted payload length in bytes.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ingress_port_tdata  input  16  AXI-Stream beat; first-on-wire byte in [15:8].
REQ-005 ingress_port_tvalid  input  1  beat valid.
REQ-006 ingress_port_tlast  input  1  final beat of frame.
REQ-007 ingress_port_tready  output  1  block accepts beat.
REQ-008 writedata  input  8  Avalon slave write data.
REQ-009 write  input  1  Avalon write strobe.
REQ-010 read  input  1  Avalon read strobe.
REQ-011 chipselect  input  1  Avalon select.
REQ-012 address  input  8  Avalon register address.
REQ-013 readdata  output  8  Avalon read data.

Function
REQ-014 Beat accepted only when tvalid and tready are both high; beat index counts accepted beats from 0 per frame.
REQ-015 tready = NOT pause bit (ctrl bit0); no other backpressure.
REQ-016 Frame layout: beats 0-2 = 0xAAAA, beat 3 = 0xAAAB, beats 4-6 dst MAC bytes 0-5, 7-9 src MAC bytes 0-5, beat 10 length with byte0 (LSB) in [15:8], byte1 (MSB) in [7:0], beat 11 type bytes 0-1, then ceil(len/2) payload beats.
REQ-017 States: PREAMBLE (beats 0-3), HEADER (beats 4-11), PAYLOAD, DROP; reset state PREAMBLE.
REQ-018 PREAMBLE: wrong value -> error code 1, go DROP (or straight to PREAMBLE if that beat has tlast).
REQ-019 HEADER: beat 10 with len > MAX_PAYLOAD -> error code 4, DROP.
REQ-020 tlast before expected last beat (index 11+ceil(len/2)) -> error code 2 (runt), back to PREAMBLE.
REQ-021 Expected last beat without tlast -> error code 3 (long), DROP; DROP discards beats until tlast, then PREAMBLE.
REQ-022 len = 0: type beat must carry tlast; PAYLOAD skipped.
REQ-023 Checksum: 32-bit running sum of zero-extended payload bytes, [15:8] then [7:0]; for odd len the low byte of the final beat is excluded; wraps modulo 2^32.
REQ-024 Header fields and checksum captured into working registers; copied to visible registers only on good-frame completion (correct tlast), same cycle good-frame count increments.
REQ-025 Good-frame and error counters 8-bit, saturate at 255; error count increments once per bad frame; last-error register holds latest code.
REQ-026 Register map (R): 0-5 dst MAC, 6-11 src MAC, 12-13 length LE, 14-15 type, 16-19 checksum LE, 20 good count, 21 error count, 22 last error, 23 status {6'b0, paused, busy}; busy = state != PREAMBLE or beat index != 0.
REQ-027 Address 24 (W) ctrl: bit0 pause (held), bit1 clear counters and last error (self-clearing, no storage); reads of 24 return {7'b0, pause}.
REQ-028 Read latency 1 cycle; readdata = 0 in cycles without chipselect&read or for unmapped addresses; writes to other addresses ignored.
REQ-029 Clear coincident with frame completion/error: clear wins, count ends 0.
REQ-030 Pause asserted mid-frame stalls the frame; state preserved, resumes on deassert.

Reset
REQ-031 Reset clears all registers, counters, checksum, pause, beat index; state PREAMBLE; readdata 0; tready 1.
REQ-032 Reset mid-frame discards the partial frame with no counter update.

Structure
REQ-033 Error codes, state enum, register addresses and preamble/SFD constants in shared package packet_filter_pkg.
REQ-034 One sub-module natural: frame_checker_regs (Avalon register file, counters, clear/pause logic).

Verification
REQ-035 Good frame dst 01..06, src 11..16, len 4, type 0x0800, payload 01 02 03 04 -> good=1, checksum reg 16 = 0x0A, length regs 04 00.
REQ-036 Odd len 3, payload beats 0x0102, 0x03FF -> checksum 0x06 (0xFF excluded).
REQ-037 Beat 3 = 0xAAAA, tlast at beat 15 -> error=1, last error 1, good unchanged, next good frame accepted.
REQ-038 len 4 with tlast on beat 12 -> code 2; len 2 without tlast on beat 12, tlast on beat 14 -> code 3; len 1501 -> code 4.
REQ-039 Pause set mid-payload for 10 cycles -> tready 0, no beats lost, checksum correct after resume.
REQ-040 Clear written in same cycle as good-frame tlast -> good count reads 0; 300 good frames -> count 255.

Source files
------------

// File: rtl/packet_filter_pkg.sv
// packet_filter_pkg: shared states, error codes, register addresses and preamble constants
package packet_filter_pkg;
    typedef enum logic [1:0] {ST_PREAMBLE, ST_HEADER, ST_PAYLOAD, ST_DROP} state_t;
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_PREAMBLE = 3'd1;
    localparam logic [2:0] ERR_RUNT = 3'd2;
    localparam logic [2:0] ERR_LONG = 3'd3;
    localparam logic [2:0] ERR_LEN = 3'd4;
    localparam logic [15:0] PREAMBLE_WORD = 16'hAAAA;
    localparam logic [15:0] SFD_WORD = 16'hAAAB;
    localparam int ADDR_SRC = 6;
    localparam int ADDR_LEN = 12;
    localparam int ADDR_TYPE = 14;
    localparam int ADDR_CSUM = 16;
    localparam int ADDR_GOOD = 20;
    localparam int ADDR_ERR = 21;
    localparam int ADDR_LAST_ERR = 22;
    localparam int ADDR_STATUS = 23;
    localparam logic [7:0] ADDR_CTRL = 8'd24;
endpackage

// File: rtl/frame_checker_regs.sv
// frame_checker_regs: Avalon register file with visible frame fields, counters, pause and clear
// Ports: clk/reset; Avalon chipselect/read/write/address/writedata/readdata;
//        pause (ctrl bit0); busy from the parser; good_evt/err_evt/err_code frame outcome;
//        dst/src/len/typ/csum working values copied on good_evt.
module frame_checker_regs
    import packet_filter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [7:0]       address,
    input  logic [7:0]       writedata,
    output logic [7:0]       readdata,
    output logic             pause,
    input  logic             busy,
    input  logic             good_evt,
    input  logic             err_evt,
    input  logic [2:0]       err_code,
    input  logic [5:0][7:0]  dst,
    input  logic [5:0][7:0]  src,
    input  logic [15:0]      len,
    input  logic [1:0][7:0]  typ,
    input  logic [31:0]      csum
);
    logic [5:0][7:0] dst_v, src_v;
    logic [15:0] len_v;
    logic [1:0][7:0] typ_v;
    logic [31:0] csum_v;
    logic [7:0] good_cnt, err_cnt, last_err;
    logic [7:0] map [0:24];
    logic wr_ctrl, clr;
    logic unused_wdata;
    assign unused_wdata = ^writedata[7:2];
    assign wr_ctrl = chipselect && write && address == ADDR_CTRL;
    assign clr = wr_ctrl && writedata[1];
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            map[i] = dst_v[i];
            map[i + ADDR_SRC] = src_v[i];
        end
        map[ADDR_LEN] = len_v[7:0];
        map[ADDR_LEN + 1] = len_v[15:8];
        map[ADDR_TYPE] = typ_v[0];
        map[ADDR_TYPE + 1] = typ_v[1];
        for (int i = 0; i < 4; i++) map[ADDR_CSUM + i] = csum_v[8*i +: 8];
        map[ADDR_GOOD] = good_cnt;
        map[ADDR_ERR] = err_cnt;
        map[ADDR_LAST_ERR] = last_err;
        map[ADDR_STATUS] = {6'b0, pause, busy};
        map[24] = {7'b0, pause};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_v <= '0;
            src_v <= '0;
            len_v <= '0;
            typ_v <= '0;
            csum_v <= '0;
            good_cnt <= '0;
            err_cnt <= '0;
            last_err <= '0;
            pause <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr_ctrl) pause <= writedata[0];
            if (good_evt) begin
                dst_v <= dst;
                src_v <= src;
                len_v <= len;
                typ_v <= typ;
                csum_v <= csum;
            end
            // clear beats a coincident frame outcome
            if (clr) good_cnt <= '0;
            else if (good_evt && good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
            if (clr) begin
                err_cnt <= '0;
                last_err <= '0;
            end else if (err_evt) begin
                err_cnt <= err_cnt == 8'hFF ? err_cnt : err_cnt + 8'd1;
                last_err <= {5'b0, err_code};
            end
            readdata <= (chipselect && read && address <= ADDR_CTRL) ? map[address[4:0]] : 8'd0;
        end
    end
endmodule

// File: rtl/frame_checker.sv
// frame_checker: parses AXI-Stream frames, checks preamble/length/framing, sums payload, exposes results over Avalon
// Ports: clk/reset; ingress_port_* AXI-Stream sink (first byte in [15:8]);
//        chipselect/read/write/address/writedata/readdata Avalon register slave.
module frame_checker
    import packet_filter_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ingress_port_tdata,
    input  logic        ingress_port_tvalid,
    input  logic        ingress_port_tlast,
    output logic        ingress_port_tready,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        read,
    input  logic        chipselect,
    input  logic [7:0]  address,
    output logic [7:0]  readdata
);
    state_t state;
    logic pause, accept, good_evt, err_evt, odd_last, tlast;
    logic [2:0] err_code;
    logic [15:0] idx, len_w, len_in, last_idx, kd, ks, d;
    logic [5:0][7:0] dst_w, src_w;
    logic [1:0][7:0] typ_w, typ_out;
    logic [31:0] csum_w, csum_sum, csum_out;
    assign d = ingress_port_tdata;
    assign tlast = ingress_port_tlast;
    assign ingress_port_tready = ~pause;
    always_comb begin
        accept = ingress_port_tvalid && !pause;
        len_in = {d[7:0], d[15:8]};
        last_idx = 16'd11 + ((len_w + 16'd1) >> 1);
        kd = idx - 16'd4;
        ks = idx - 16'd7;
        // odd length: low byte of the final payload beat is padding
        odd_last = len_w[0] && idx == last_idx;
        csum_sum = csum_w + {24'd0, d[15:8]} + (odd_last ? 32'd0 : {24'd0, d[7:0]});
        err_code = ERR_NONE;
        if (accept)
            case (state)
                ST_PREAMBLE: err_code = d != (idx == 16'd3 ? SFD_WORD : PREAMBLE_WORD) ? ERR_PREAMBLE :
                                        tlast ? ERR_RUNT : ERR_NONE;
                ST_HEADER:   err_code = (idx == 16'd10 && len_in > 16'(MAX_PAYLOAD)) ? ERR_LEN :
                                        (idx == 16'd11 && len_w == 16'd0) ? (tlast ? ERR_NONE : ERR_LONG) :
                                        tlast ? ERR_RUNT : ERR_NONE;
                ST_PAYLOAD:  err_code = idx == last_idx ? (tlast ? ERR_NONE : ERR_LONG) :
                                        tlast ? ERR_RUNT : ERR_NONE;
                default:     err_code = ERR_NONE;
            endcase
        err_evt = err_code != ERR_NONE;
        good_evt = accept && tlast && ((state == ST_HEADER && idx == 16'd11 && len_w == 16'd0) ||
                                       (state == ST_PAYLOAD && idx == last_idx));
        // a zero-length frame completes on the type beat, before it is registered
        typ_out = state == ST_PAYLOAD ? typ_w : {d[7:0], d[15:8]};
        csum_out = state == ST_PAYLOAD ? csum_sum : csum_w;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_PREAMBLE;
            idx <= '0;
            dst_w <= '0;
            src_w <= '0;
            len_w <= '0;
            typ_w <= '0;
            csum_w <= '0;
        end else if (accept) begin
            if (state == ST_PREAMBLE && idx == 16'd0) csum_w <= '0;
            if (state == ST_HEADER && idx <= 16'd6) begin
                dst_w[{kd[1:0], 1'b0}] <= d[15:8];
                dst_w[{kd[1:0], 1'b1}] <= d[7:0];
            end
            if (state == ST_HEADER && idx >= 16'd7 && idx <= 16'd9) begin
                src_w[{ks[1:0], 1'b0}] <= d[15:8];
                src_w[{ks[1:0], 1'b1}] <= d[7:0];
            end
            if (state == ST_HEADER && idx == 16'd10) len_w <= len_in;
            if (state == ST_HEADER && idx == 16'd11) typ_w <= {d[7:0], d[15:8]};
            if (state == ST_PAYLOAD) csum_w <= csum_sum;
            if (err_evt) begin
                state <= tlast ? ST_PREAMBLE : ST_DROP;
                idx <= '0;
            end else if (good_evt || state == ST_DROP) begin
                state <= (good_evt || tlast) ? ST_PREAMBLE : ST_DROP;
                idx <= '0;
            end else begin
                idx <= idx + 16'd1;
                if (state == ST_PREAMBLE && idx == 16'd3) state <= ST_HEADER;
                if (state == ST_HEADER && idx == 16'd11) state <= ST_PAYLOAD;
            end
        end
    end
    frame_checker_regs u_regs (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .pause      (pause),
        .busy       (state != ST_PREAMBLE || idx != 16'd0),
        .good_evt   (good_evt),
        .err_evt    (err_evt),
        .err_code   (err_code),
        .dst        (dst_w),
        .src        (src_w),
        .len        (len_w),
        .typ        (typ_out),
        .csum       (csum_out)
    );
endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: directed self-checking bench for frame_checker
module tb_frame_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] tdata = '0;
    logic tvalid = 1'b0, tlast = 1'b0, tready;
    logic [7:0] writedata = '0, address = '0, readdata;
    logic write = 1'b0, read = 1'b0, chipselect = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    frame_checker dut (
        .clk                 (clk),
        .reset               (reset),
        .ingress_port_tdata  (tdata),
        .ingress_port_tvalid (tvalid),
        .ingress_port_tlast  (tlast),
        .ingress_port_tready (tready),
        .writedata           (writedata),
        .write               (write),
        .read                (read),
        .chipselect          (chipselect),
        .address             (address),
        .readdata            (readdata)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic beat(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        tdata = d;
        tvalid = 1'b1;
        tlast = l;
        while (!tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("tready_timeout", 32'(tready), 32'd1);
        @(posedge clk);
    endtask
    task automatic idle();
        @(negedge clk);
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask
    task automatic hdr(input logic [15:0] len, input logic [15:0] typ, input logic l11);
        beat(16'hAAAA, 0); beat(16'hAAAA, 0); beat(16'hAAAA, 0); beat(16'hAAAB, 0);
        beat(16'h0102, 0); beat(16'h0304, 0); beat(16'h0506, 0);
        beat(16'h1112, 0); beat(16'h1314, 0); beat(16'h1516, 0);
        beat({len[7:0], len[15:8]}, 0);
        beat(typ, l11);
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask
    task automatic rc(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chk(tag, 32'(readdata), 32'(exp));
        chipselect = 1'b0; read = 1'b0;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("reset_tready", 32'(tready), 32'd1);
        chk("reset_readdata", 32'(readdata), 32'd0);
        reset = 1'b0;
        rc("reset_status", 8'd23, 8'h00);
        rc("reset_good", 8'd20, 8'h00);
        @(negedge clk);
        chk("readdata_idle_zero", 32'(readdata), 32'd0);
        // good frame, len 4
        hdr(16'd4, 16'h0800, 0); beat(16'h0102, 0); beat(16'h0304, 1); idle();
        rc("good_cnt_1", 8'd20, 8'd1);
        rc("csum0", 8'd16, 8'h0A);
        rc("csum1", 8'd17, 8'h00);
        rc("csum3", 8'd19, 8'h00);
        rc("len_lo", 8'd12, 8'h04);
        rc("len_hi", 8'd13, 8'h00);
        rc("dst0", 8'd0, 8'h01);
        rc("dst5", 8'd5, 8'h06);
        rc("src0", 8'd6, 8'h11);
        rc("src5", 8'd11, 8'h16);
        rc("type0", 8'd14, 8'h08);
        rc("type1", 8'd15, 8'h00);
        rc("err_cnt_0", 8'd21, 8'd0);
        rc("status_idle", 8'd23, 8'h00);
        rc("unmapped", 8'd30, 8'h00);
        wr(8'd5, 8'h77);
        rc("write_ignored", 8'd5, 8'h06);
        // odd length 3
        hdr(16'd3, 16'h0800, 0); beat(16'h0102, 0); beat(16'h03FF, 1); idle();
        rc("good_cnt_2", 8'd20, 8'd2);
        rc("csum_odd", 8'd16, 8'h06);
        // bad SFD, drop to tlast on beat 15
        beat(16'hAAAA, 0); beat(16'hAAAA, 0); beat(16'hAAAA, 0); beat(16'hAAAA, 0); idle();
        rc("status_drop", 8'd23, 8'h01);
        for (int i = 4; i <= 15; i++) beat(16'h1234, i == 15);
        idle();
        rc("pre_err_cnt", 8'd21, 8'd1);
        rc("pre_last_err", 8'd22, 8'd1);
        rc("pre_good_same", 8'd20, 8'd2);
        hdr(16'd4, 16'h0800, 0); beat(16'h0102, 0); beat(16'h0304, 1); idle();
        rc("good_after_drop", 8'd20, 8'd3);
        // runt
        hdr(16'd4, 16'h0800, 0); beat(16'h0102, 1); idle();
        rc("runt_err_cnt", 8'd21, 8'd2);
        rc("runt_code", 8'd22, 8'd2);
        // long
        hdr(16'd2, 16'h0800, 0); beat(16'h0102, 0); beat(16'h0304, 0); beat(16'h0506, 1); idle();
        rc("long_err_cnt", 8'd21, 8'd3);
        rc("long_code", 8'd22, 8'd3);
        rc("long_good_same", 8'd20, 8'd3);
        rc("long_status", 8'd23, 8'h00);
        // oversize length 1501
        hdr(16'd1501, 16'h0800, 1); idle();
        rc("len_err_cnt", 8'd21, 8'd4);
        rc("len_code", 8'd22, 8'd4);
        // zero length frame
        hdr(16'd0, 16'h86DD, 1); idle();
        rc("zero_good", 8'd20, 8'd4);
        rc("zero_len", 8'd12, 8'h00);
        rc("zero_csum", 8'd16, 8'h00);
        rc("zero_type0", 8'd14, 8'h86);
        rc("zero_type1", 8'd15, 8'hDD);
        // pause mid-payload
        hdr(16'd6, 16'h0800, 0); beat(16'h0102, 0); idle();
        wr(8'd24, 8'h01);
        tdata = 16'h0304; tvalid = 1'b1;
        rc("pause_reg", 8'd24, 8'h01);
        rc("pause_status", 8'd23, 8'h03);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("paused_tready", 32'(tready), 32'd0);
        end
        tvalid = 1'b0;
        wr(8'd24, 8'h00);
        chk("resume_tready", 32'(tready), 32'd1);
        beat(16'h0304, 0); beat(16'h0506, 1); idle();
        rc("pause_good", 8'd20, 8'd5);
        rc("pause_csum", 8'd16, 8'h15);
        rc("unpause_reg", 8'd24, 8'h00);
        // clear coincident with good tlast
        hdr(16'd2, 16'h0800, 0);
        @(negedge clk);
        tdata = 16'h0102; tvalid = 1'b1; tlast = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 8'd24; writedata = 8'h02;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; chipselect = 1'b0; write = 1'b0;
        rc("clear_good", 8'd20, 8'd0);
        rc("clear_err", 8'd21, 8'd0);
        rc("clear_last_err", 8'd22, 8'd0);
        rc("clear_csum_copied", 8'd16, 8'h03);
        rc("clear_no_pause", 8'd24, 8'h00);
        // saturation
        for (int f = 0; f < 300; f++) hdr(16'd0, 16'h0800, 1);
        idle();
        rc("good_saturate", 8'd20, 8'd255);
        // reset mid-frame
        beat(16'hAAAA, 0); beat(16'hAAAA, 0); beat(16'hAAAA, 0); beat(16'hAAAB, 0); beat(16'h0102, 0); idle();
        rc("mid_busy", 8'd23, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tready", 32'(tready), 32'd1);
        chk("rst_readdata", 32'(readdata), 32'd0);
        reset = 1'b0;
        rc("rst_good", 8'd20, 8'd0);
        rc("rst_status", 8'd23, 8'h00);
        hdr(16'd4, 16'h0800, 0); beat(16'h0102, 0); beat(16'h0304, 1); idle();
        rc("post_rst_good", 8'd20, 8'd1);
        rc("post_rst_err", 8'd21, 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
